pump_scheduler: RTL and testbench

Shares one supply pump between N tank level controllers. Each controller's `motor` demand becomes a fill request here. The scheduler grants one tank at a time through a one-hot inlet valve select, using round-robin order. It enforces valve-settle dead time, minimum and maximum pump run times, and a dry-source lockout, and it is the only block that drives the physical pump.

---
 rtl/water_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/pump_scheduler.sv | 141 ++++++++++++++
 tb/tb_pump_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/water_pkg.sv
// Shared types and helpers for the water plant blocks.
// Holds FSM states, tank level codes and clog2.
package water_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    RUN      = 3'd2,
    COAST    = 3'd3,
    DRY_HOLD = 3'd4
  } sched_state_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } level_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Searches from ptr+1 upward with wrap-around.
module rr_arbiter
  import water_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [N-1:0]          gnt,
  output logic [clog2(N)-1:0]   idx,
  output logic                  valid
);

  localparam int IW = clog2(N);

  // first requester after the pointer wins
  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        idx    = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pump_scheduler.sv
// Shares one supply pump between several tanks.
// Round-robin grants with settle gap, run limits and dry lockout.
module pump_scheduler
  import water_pkg::*;
#(
  parameter int N_TANKS = 4,
  parameter int MIN_RUN = 16,
  parameter int MAX_RUN = 256,
  parameter int GAP     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_TANKS-1:0]         req,
  input  logic                       dry,
  output logic [N_TANKS-1:0]         valve_sel,
  output logic                       pump_on,
  output logic [clog2(N_TANKS)-1:0]  grant_id,
  output logic                       dry_lock
);

  localparam int IW = clog2(N_TANKS);
  localparam int GW = clog2(GAP + 1);
  localparam int RW = clog2(MAX_RUN);

  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(MAX_RUN - 1);
  localparam logic [RW-1:0] MIN_LAST = RW'(MIN_RUN - 1);

  sched_state_t        state;
  logic [IW-1:0]       ptr;
  logic [GW-1:0]       gap_cnt;
  logic [RW-1:0]       run_cnt;

  logic [N_TANKS-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_valid;
  logic                cur_req;
  logic                others;
  logic                run_stop;

  rr_arbiter #(
    .N(N_TANKS)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign cur_req  = req[grant_id];
  assign others   = |(req & ~valve_sel);
  assign run_stop = dry
                 || (!cur_req && run_cnt >= MIN_LAST)
                 || (run_cnt == RUN_LAST && others);

  // grant sequencing, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= IW'(N_TANKS - 1);
      gap_cnt   <= '0;
      run_cnt   <= '0;
      valve_sel <= '0;
      pump_on   <= 1'b0;
      grant_id  <= '0;
      dry_lock  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          gap_cnt <= '0;
          if (dry) begin
            state    <= DRY_HOLD;
            dry_lock <= 1'b1;
          end else if (arb_valid) begin
            state     <= SETTLE;
            valve_sel <= arb_gnt;
            grant_id  <= arb_idx;
          end
        end
        SETTLE: begin
          if (dry || !cur_req) begin
            state   <= COAST;
            gap_cnt <= '0;
            ptr     <= grant_id;
          end else if (gap_cnt == GAP_LAST) begin
            state   <= RUN;
            pump_on <= 1'b1;
            run_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        RUN: begin
          if (run_stop) begin
            state   <= COAST;
            pump_on <= 1'b0;
            gap_cnt <= '0;
            ptr     <= grant_id;
          end else if (run_cnt == RUN_LAST) begin
            run_cnt <= '0;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        COAST: begin
          if (gap_cnt == GAP_LAST) begin
            valve_sel <= '0;
            gap_cnt   <= '0;
            if (dry) begin
              state    <= DRY_HOLD;
              dry_lock <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DRY_HOLD: begin
          if (dry) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            state    <= IDLE;
            dry_lock <= 1'b0;
            gap_cnt  <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          valve_sel <= '0;
          pump_on   <= 1'b0;
          dry_lock  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pump_scheduler.sv
// Directed and random checks for pump_scheduler.
// N=4, MIN_RUN=16, MAX_RUN=64, GAP=4.
module tb_pump_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       dry;
  logic [3:0] valve_sel;
  logic       pump_on;
  logic [1:0] grant_id;
  logic       dry_lock;

  int n_checks;
  int n_fail;

  pump_scheduler #(
    .N_TANKS(4),
    .MIN_RUN(16),
    .MAX_RUN(64),
    .GAP(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .dry       (dry),
    .valve_sel (valve_sel),
    .pump_on   (pump_on),
    .grant_id  (grant_id),
    .dry_lock  (dry_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = '0;
    dry   = 1'b0;
    step(2);
    n_checks++;
    if (valve_sel !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_valve got=%b exp=0000", valve_sel);
    end
    n_checks++;
    if (pump_on !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pump got=%b exp=0", pump_on);
    end
    n_checks++;
    if (grant_id !== 2'd0 || dry_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_id_lock got=%0d/%b exp=0/0",
               grant_id, dry_lock);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_single;
    req = 4'b0001;
    step(1);
    n_checks++;
    if (valve_sel !== 4'b0001 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_grant got=%b/%0d exp=0001/0",
               valve_sel, grant_id);
    end
    step(3);
    n_checks++;
    if (pump_on !== 1'b0) begin
      n_fail++;
      $display("FAIL single_settle got=%b exp=0", pump_on);
    end
    step(1);
    n_checks++;
    if (pump_on !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pump_on got=%b exp=1", pump_on);
    end
    step(20);
    req = 4'b0000;
    step(1);
    n_checks++;
    if (pump_on !== 1'b0 || valve_sel !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_release got=%b/%b exp=0/0001",
               pump_on, valve_sel);
    end
    step(3);
    n_checks++;
    if (valve_sel !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_coast got=%b exp=0001", valve_sel);
    end
    step(1);
    n_checks++;
    if (valve_sel !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_close got=%b exp=0000", valve_sel);
    end
  endtask

  task automatic test_rr_preempt;
    req = 4'b1010;
    step(1);
    n_checks++;
    if (grant_id !== 2'd1 || valve_sel !== 4'b0010) begin
      n_fail++;
      $display("FAIL rr_first got=%0d/%b exp=1/0010",
               grant_id, valve_sel);
    end
    step(4);
    step(63);
    n_checks++;
    if (pump_on !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_run63 got=%b exp=1", pump_on);
    end
    step(1);
    n_checks++;
    if (pump_on !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_preempt got=%b exp=0", pump_on);
    end
    step(5);
    n_checks++;
    if (grant_id !== 2'd3 || valve_sel !== 4'b1000) begin
      n_fail++;
      $display("FAIL rr_second got=%0d/%b exp=3/1000",
               grant_id, valve_sel);
    end
    step(4);
    step(64);
    n_checks++;
    if (pump_on !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_preempt2 got=%b exp=0", pump_on);
    end
    step(5);
    n_checks++;
    if (grant_id !== 2'd1 || valve_sel !== 4'b0010) begin
      n_fail++;
      $display("FAIL rr_wrap got=%0d/%b exp=1/0010",
               grant_id, valve_sel);
    end
    req = 4'b0000;
    step(4);
    n_checks++;
    if (valve_sel !== 4'b0010 || pump_on !== 1'b0) begin
      n_fail++;
      $display("FAIL settle_drop got=%b/%b exp=0010/0",
               valve_sel, pump_on);
    end
    step(1);
    n_checks++;
    if (valve_sel !== 4'b0000) begin
      n_fail++;
      $display("FAIL settle_drop_close got=%b exp=0000", valve_sel);
    end
  endtask

  task automatic test_min_run;
    int cnt;
    req = 4'b0001;
    step(1);
    n_checks++;
    if (grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL min_grant got=%0d exp=0", grant_id);
    end
    step(4);
    cnt = pump_on ? 1 : 0;
    step(2);
    if (pump_on) cnt += 2;
    req = 4'b0000;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (!pump_on) break;
      cnt++;
    end
    n_checks++;
    if (cnt != 16) begin
      n_fail++;
      $display("FAIL min_run got=%0d exp=16", cnt);
    end
    step(4);
    n_checks++;
    if (valve_sel !== 4'b0000) begin
      n_fail++;
      $display("FAIL min_close got=%b exp=0000", valve_sel);
    end
  endtask

  task automatic test_dry;
    req = 4'b0100;
    step(5);
    step(5);
    dry = 1'b1;
    req = 4'b0000;
    step(1);
    n_checks++;
    if (pump_on !== 1'b0 || valve_sel !== 4'b0100) begin
      n_fail++;
      $display("FAIL dry_stop got=%b/%b exp=0/0100",
               pump_on, valve_sel);
    end
    step(3);
    n_checks++;
    if (dry_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL dry_coast_lock got=%b exp=0", dry_lock);
    end
    step(1);
    n_checks++;
    if (dry_lock !== 1'b1 || valve_sel !== 4'b0000) begin
      n_fail++;
      $display("FAIL dry_lock got=%b/%b exp=1/0000",
               dry_lock, valve_sel);
    end
    dry = 1'b0;
    step(3);
    dry = 1'b1;
    step(1);
    dry = 1'b0;
    step(3);
    n_checks++;
    if (dry_lock !== 1'b1) begin
      n_fail++;
      $display("FAIL dry_restart got=%b exp=1", dry_lock);
    end
    step(1);
    n_checks++;
    if (dry_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL dry_release got=%b exp=0", dry_lock);
    end
    dry = 1'b1;
    step(1);
    n_checks++;
    if (dry_lock !== 1'b1) begin
      n_fail++;
      $display("FAIL dry_idle got=%b exp=1", dry_lock);
    end
    dry = 1'b0;
    step(4);
    n_checks++;
    if (dry_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL dry_idle_rel got=%b exp=0", dry_lock);
    end
  endtask

  task automatic test_reset_mid;
    req = 4'b1111;
    step(1);
    n_checks++;
    if (grant_id !== 2'd3) begin
      n_fail++;
      $display("FAIL mid_grant got=%0d exp=3", grant_id);
    end
    step(7);
    n_checks++;
    if (pump_on !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_run got=%b exp=1", pump_on);
    end
    rst_n = 1'b0;
    step(1);
    n_checks++;
    if (pump_on !== 1'b0 || valve_sel !== 4'b0000 ||
        grant_id !== 2'd0 || dry_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got=%b/%b/%0d/%b exp=0/0000/0/0",
               pump_on, valve_sel, grant_id, dry_lock);
    end
    rst_n = 1'b1;
    step(1);
    n_checks++;
    if (grant_id !== 2'd0 || valve_sel !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_after got=%0d/%b exp=0/0001",
               grant_id, valve_sel);
    end
    req = 4'b0000;
    step(5);
  endtask

  task automatic test_random;
    logic [3:0] pv;
    logic       pp;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 19) == 0) req = 4'($urandom);
      dry = ($urandom_range(0, 63) == 0);
      pv = valve_sel;
      pp = pump_on;
      step(1);
      n_checks++;
      if ($onehot0(valve_sel) !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd_onehot got=%b exp=onehot0", valve_sel);
      end
      n_checks++;
      if (pump_on && valve_sel == 4'b0000) begin
        n_fail++;
        $display("FAIL rnd_no_valve got=%b/%b exp=valve set",
                 pump_on, valve_sel);
      end
      n_checks++;
      if (pp && valve_sel !== pv) begin
        n_fail++;
        $display("FAIL rnd_valve_hold got=%b exp=%b", valve_sel, pv);
      end
    end
    req = '0;
    dry = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = '0;
    dry      = 1'b0;
    test_reset;
    test_single;
    test_rr_preempt;
    test_min_run;
    test_dry;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
